// File: rtl/kcpsm6_io_ports.sv
// Port-mapped I/O block for the KCPSM6 bus: synchronised input channels with change flags,
// write-1-to-clear status, interrupt mask with level irq, and strobed output registers.
module kcpsm6_io_ports #(
  parameter int         NUM_IN      = 4,
  parameter int         IN_WIDTH    = 2,
  parameter int         NUM_OUT     = 1,
  parameter logic [7:0] IN_BASE     = 8'h01,
  parameter logic [7:0] OUT_BASE    = 8'h05,
  parameter logic [7:0] STAT_ADDR   = 8'h10,
  parameter logic [7:0] MASK_ADDR   = 8'h11,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rdl_n,
  input  logic [7:0]                   port_id,
  input  logic                         write_strobe,
  input  logic                         k_write_strobe,
  input  logic                         read_strobe,
  input  logic [7:0]                   out_port,
  output logic [7:0]                   in_port,
  input  logic [NUM_IN*IN_WIDTH-1:0]   in_data,
  output logic [NUM_OUT*8-1:0]         out_data,
  output logic [NUM_OUT-1:0]           out_wr,
  output logic                         irq
);

  localparam int DW = NUM_IN * IN_WIDTH;

  function automatic bit f_overlap(input int a, input int na, input int b, input int nb);
    return (a < b + nb) && (b < a + na);
  endfunction

  localparam bit ADDR_CLASH =
      f_overlap(int'(IN_BASE),   NUM_IN,  int'(OUT_BASE),  NUM_OUT) ||
      f_overlap(int'(IN_BASE),   NUM_IN,  int'(STAT_ADDR), 1)       ||
      f_overlap(int'(IN_BASE),   NUM_IN,  int'(MASK_ADDR), 1)       ||
      f_overlap(int'(OUT_BASE),  NUM_OUT, int'(STAT_ADDR), 1)       ||
      f_overlap(int'(OUT_BASE),  NUM_OUT, int'(MASK_ADDR), 1)       ||
      f_overlap(int'(STAT_ADDR), 1,       int'(MASK_ADDR), 1);

  localparam bit PARAM_RANGE_BAD =
      (NUM_IN < 1) || (NUM_IN > 8) || (IN_WIDTH < 1) || (IN_WIDTH > 8) ||
      (NUM_OUT < 1) || (NUM_OUT > 8) || (SYNC_STAGES < 2) || (SYNC_STAGES > 3);

  if (ADDR_CLASH) begin : g_addr_clash
    $error("kcpsm6_io_ports: IN/OUT/STAT/MASK port address ranges overlap");
  end
  if (PARAM_RANGE_BAD) begin : g_param_range
    $error("kcpsm6_io_ports: parameter out of supported range");
  end

  logic [DW-1:0]      r_sync [SYNC_STAGES];
  logic [DW-1:0]      r_prev;
  logic [2:0]         r_prime_cnt;
  logic [NUM_IN-1:0]  r_flags;
  logic [NUM_IN-1:0]  r_mask;
  logic               r_irq;
  logic [7:0]         r_in_port;
  logic [NUM_OUT*8-1:0] r_out;
  logic [NUM_OUT-1:0] r_wr;

  logic [DW-1:0]      w_sync;
  logic               w_prime;
  logic [NUM_IN-1:0]  w_change;
  logic [NUM_IN-1:0]  w_clr;
  logic               w_stat_wr;
  logic               w_mask_wr;
  logic [NUM_OUT-1:0] w_wr;
  logic [7:0]         w_rd;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  // Compare stays off until the chain and prev both hold post-reset samples.
  assign w_prime   = (r_prime_cnt == 3'(SYNC_STAGES + 1));
  assign w_stat_wr = write_strobe && (port_id == STAT_ADDR);
  assign w_mask_wr = write_strobe && (port_id == MASK_ADDR);
  assign w_clr     = w_stat_wr ? out_port[NUM_IN-1:0] : {NUM_IN{1'b0}};

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out_dec
    localparam logic [7:0] ADDR  = 8'(int'(OUT_BASE) + j);
    localparam logic [3:0] KADDR = 4'(int'(OUT_BASE[3:0]) + j);
    assign w_wr[j] = (write_strobe   && (port_id == ADDR)) ||
                     (k_write_strobe && (port_id[3:0] == KADDR));
  end

  // Per-channel change detection between synchronised sample and its delayed copy
  always_comb begin
    w_change = {NUM_IN{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      w_change[i] = w_prime && (w_sync[i*IN_WIDTH +: IN_WIDTH] != r_prev[i*IN_WIDTH +: IN_WIDTH]);
    end
  end

  // Read data mux; address ranges are disjoint so the terms can be OR-ed
  always_comb begin
    w_rd = 8'h00;
    for (int i = 0; i < NUM_IN; i++) begin
      w_rd = w_rd | ((port_id == 8'(int'(IN_BASE) + i)) ? 8'(w_sync[i*IN_WIDTH +: IN_WIDTH]) : 8'h00);
    end
    w_rd = w_rd | ((port_id == STAT_ADDR) ? 8'(r_flags) : 8'h00);
    w_rd = w_rd | ((port_id == MASK_ADDR) ? 8'(r_mask)  : 8'h00);
  end

  // Input synchroniser, previous-value stage and prime counter
  always_ff @(posedge clk or negedge rdl_n) begin
    if (!rdl_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev      <= '0;
      r_prime_cnt <= 3'd0;
    end else begin
      r_sync[0] <= in_data;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev <= w_sync;
      if (!w_prime) r_prime_cnt <= r_prime_cnt + 3'd1;
    end
  end

  // Status flags (set beats clear), mask, irq and registered read data
  always_ff @(posedge clk or negedge rdl_n) begin
    if (!rdl_n) begin
      r_flags   <= {NUM_IN{1'b0}};
      r_mask    <= {NUM_IN{1'b0}};
      r_irq     <= 1'b0;
      r_in_port <= 8'h00;
    end else begin
      r_flags   <= (r_flags & ~w_clr) | w_change;
      if (w_mask_wr) r_mask <= out_port[NUM_IN-1:0];
      r_irq     <= |(r_flags & r_mask);
      r_in_port <= w_rd;
    end
  end

  // Output registers and their one-cycle write pulses
  always_ff @(posedge clk or negedge rdl_n) begin
    if (!rdl_n) begin
      r_out <= '0;
      r_wr  <= {NUM_OUT{1'b0}};
    end else begin
      r_wr <= w_wr;
      for (int j = 0; j < NUM_OUT; j++) begin
        if (w_wr[j]) r_out[j*8 +: 8] <= out_port;
      end
    end
  end

  assign in_port  = r_in_port;
  assign out_data = r_out;
  assign out_wr   = r_wr;
  assign irq      = r_irq;

  kcpsm6_io_ports_chk u_chk (
    .clk          (clk),
    .rdl_n        (rdl_n),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe)
  );

endmodule

// Bus protocol checker: KCPSM6 never issues INPUT and OUTPUT strobes together.
module kcpsm6_io_ports_chk (
  input logic clk,
  input logic rdl_n,
  input logic write_strobe,
  input logic read_strobe
);
  a_no_rd_wr: assert property (@(posedge clk) disable iff (!rdl_n) !(write_strobe && read_strobe));
endmodule

// File: doc/kcpsm6_io_ports.md
Name: kcpsm6_io_ports

Overview:
- Parametrised port-mapped I/O controller for the KCPSM6 processor bus. It replaces the hand-coded port_id decode in the processor top level.
- NUM_IN synchronised input channels, each readable at its own port address, with per-channel change detection.
- A sticky change-flag status register with write-1-to-clear, an interrupt mask and a level interrupt.
- NUM_OUT write-strobed output registers, also writable through k_write_strobe (OUTPUTK).

Parameters:
- NUM_IN, 4, number of input channels, 1..8.
- IN_WIDTH, 2, bits per input channel, 1..8; zero-extended to 8 bits on in_port.
- NUM_OUT, 1, number of 8-bit output registers, 1..8.
- IN_BASE, 8'h01, port_id of input channel 0; channel i is at IN_BASE+i.
- OUT_BASE, 8'h05, port_id of output register 0; register j is at OUT_BASE+j.
- STAT_ADDR, 8'h10, change-flag status port: read flags, write 1s to clear.
- MASK_ADDR, 8'h11, interrupt mask port, read/write.
- SYNC_STAGES, 2, synchroniser depth on in_data, 2..3.

Ports:
- clk  in  1  system clock.
- rdl_n  in  1  asynchronous active-low reset.
- port_id  in  8  KCPSM6 port address.
- write_strobe  in  1  OUTPUT strobe.
- k_write_strobe  in  1  OUTPUTK strobe.
- read_strobe  in  1  INPUT strobe.
- out_port  in  8  KCPSM6 write data.
- in_port  out  8  KCPSM6 read data, registered.
- in_data  in  NUM_IN*IN_WIDTH  asynchronous inputs; channel i is at bits [i*IN_WIDTH +: IN_WIDTH].
- out_data  out  NUM_OUT*8  output registers; register j is at bits [j*8 +: 8].
- out_wr  out  NUM_OUT  one-cycle pulse when register j is written.
- irq  out  1  level interrupt = |(flags & mask), registered.

Behaviour:
- Reset (rdl_n low, asynchronous):
  - Cleared: in_port, out_data, out_wr, irq, flags, mask and all synchroniser/previous-value stages.
  - The first post-reset synchronised sample must not set flags: a prime bit, cleared by reset, suppresses compare until SYNC_STAGES+1 cycles after reset release.
- Synchronisation: in_data passes through SYNC_STAGES flops, giving sync[i]. prev[i] holds sync[i] delayed one cycle.
- Change detect: sync[i] != prev[i] sets flags[i] in that cycle.
- Read path:
  - in_port is registered every clk from the current port_id:
    - IN_BASE+i (i<NUM_IN): zero-extended sync[i].
    - STAT_ADDR: flags, zero-padded above NUM_IN.
    - MASK_ADDR: mask.
    - Any other address: 8'h00.
  - Latency is one cycle, which fits the two-cycle INPUT timing where port_id is stable for 2 clocks.
  - Reads have no side effects; read_strobe is unused except by the assertion below.
- Write path, write_strobe=1:
  - port_id == OUT_BASE+j (j<NUM_OUT): out_data[j] <= out_port; out_wr[j] pulses on the next cycle for exactly 1 cycle.
  - port_id == STAT_ADDR: flags <= flags & ~out_port[NUM_IN-1:0].
  - port_id == MASK_ADDR: mask <= out_port[NUM_IN-1:0].
  - Unmapped addresses: ignored.
- k_write_strobe=1: decode only port_id[3:0] against OUT_BASE[3:0]+j (4-bit wrap). Only output registers are writable by OUTPUTK. Status and mask ignore k_write_strobe.
- Simultaneous set and clear of the same flag in one cycle: set wins, flag stays 1.
- irq = |(flags & mask), registered one cycle. It stays high until software clears the flags or the mask. No interrupt_ack handshake.
- Address overlap between the OUT, IN, STAT and MASK ranges is a parameter error. Elaboration must fail; use a generate-time check.
- write_strobe and read_strobe high together: illegal from KCPSM6; simulation assertion only.
- Reset mid-write: the write is lost and the register holds its reset value.

Test Plan:
1. Reset, then hold in_data channel 2 at 2'b11 from time 0 with defaults: after release, read port 8'h03 gives in_port=8'h03 one cycle after port_id is set. Reading port 8'h10 gives 8'h00 because the prime bit suppresses flags.
2. Write: port_id=8'h05, out_port=8'hA5, write_strobe pulse -> out_data=8'hA5 next cycle, out_wr[0] high for 1 cycle. Then port_id=8'h06, NUM_OUT=1 -> out_data unchanged, no out_wr.
3. Change and interrupt: write mask 8'h02 to 8'h11, toggle channel 1 from 2'b00 to 2'b01:
   - flags = 8'h02 after SYNC_STAGES+1 cycles; irq rises 1 cycle later.
   - Write 8'h02 to 8'h10 -> flags=0, irq low next cycle.
4. Clear/set collision: toggle channel 0 in the same cycle a write of 8'h01 to 8'h10 occurs -> flags[0] stays 1.
5. OUTPUTK: k_write_strobe, port_id=8'hF5, out_port=8'h3C -> out_data=8'h3C. The same strobe with port_id=8'h10 leaves flags unchanged.
6. Reset asserted mid-sequence after out_data=8'hFF and flags=8'h0F -> all outputs 0 immediately (asynchronous), irq=0.
